// File: rtl/bus_dma_pkg.sv
// Shared types for the DMA master / memory slave pair: engine state encodings
// and the write-response code.
package bus_dma_pkg;

    typedef enum logic [1:0] {
        RD_IDLE,
        RD_AR,
        RD_R,
        RD_DONE
    } rd_state_t;

    typedef enum logic [2:0] {
        WR_IDLE,
        WR_AW,
        WR_W,
        WR_B,
        WR_DONE
    } wr_state_t;

    localparam logic [1:0] RESP_OKAY = 2'b00;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock show-ahead FIFO. Push is ignored when full and pop is ignored
// when empty. Push and pop may happen in the same cycle.
module sync_fifo #(
    parameter int WIDTH      = 33,
    parameter int ADDR_WIDTH = 3
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    output logic             full_o,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             empty_o
);

    localparam int DEPTH = 2**ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] PTR_ONE = 1;

    logic [WIDTH-1:0]    mem_q [DEPTH];
    logic [ADDR_WIDTH:0] wr_ptr_q;
    logic [ADDR_WIDTH:0] rd_ptr_q;
    logic                do_push;
    logic                do_pop;

    // Pointers carry one extra wrap bit so that full and empty can be told apart.
    assign full_o  = (wr_ptr_q[ADDR_WIDTH] != rd_ptr_q[ADDR_WIDTH]) &&
                     (wr_ptr_q[ADDR_WIDTH-1:0] == rd_ptr_q[ADDR_WIDTH-1:0]);
    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign rdata_o = mem_q[rd_ptr_q[ADDR_WIDTH-1:0]];

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + PTR_ONE;
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_ONE;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_ptr_q[ADDR_WIDTH-1:0]] <= wdata_i;
        end
    end

endmodule

// File: rtl/bus_dma_master_memory_slave.sv
// DMA master with independent read (page-fault) and write (write-back) engines,
// connected over burst channels to an on-chip word memory slave.
//
// rd state | meaning
// RD_IDLE  | waiting for page-fault request, latches addr/len
// RD_AR    | read address offered, slave accepts in one cycle
// RD_R     | receiving one beat per cycle until rlast
// RD_DONE  | done held while request stays high
//
// wr state | meaning
// WR_IDLE  | waiting for write-back request, latches addr/len
// WR_AW    | write address offered, slave accepts in one cycle
// WR_W     | pushing beat words into the write-data FIFO
// WR_B     | waiting for the write response
// WR_DONE  | done held while request stays high
module bus_dma_master_memory_slave
    import bus_dma_pkg::*;
#(
    parameter int ADDR_WIDTH           = 32,
    parameter int READ_CHANNEL_WIDTH   = 32,
    parameter int READ_BURST_LEN       = 8,
    parameter int WRITE_CHANNEL_WIDTH  = 32,
    parameter int WRITE_BURST_LEN      = 8,
    parameter int ASYNCFIFO_ADDR_WIDTH = 3,
    parameter int MEM_ADDR_WIDTH       = 6
) (
    input  logic                       cpu_clk,
    input  logic                       cpu_rst_n,
    input  logic                       dma_page_fault_happen,
    output logic                       dma_page_fault_done,
    input  logic [ADDR_WIDTH-1:0]      dma_page_fault_addr,
    input  logic [READ_BURST_LEN-1:0]  dma_page_fault_burst_len,
    input  logic                       dma_write_back_happen,
    output logic                       dma_write_back_done,
    input  logic [ADDR_WIDTH-1:0]      dma_write_back_addr,
    input  logic [WRITE_BURST_LEN-1:0] dma_write_back_burst_len
);

    localparam logic [READ_BURST_LEN:0]   RD_BEAT_ONE = 1;
    localparam logic [WRITE_BURST_LEN:0]  WR_BEAT_ONE = 1;
    localparam logic [MEM_ADDR_WIDTH-1:0] MEM_ONE     = 1;
    localparam logic [READ_BURST_LEN-1:0] RD_LEN_ONE  = 1;

    // ---------------- read master ----------------
    rd_state_t                      rd_state_q, rd_state_d;
    logic [MEM_ADDR_WIDTH-1:0]      rd_addr_q, rd_addr_d;
    logic [READ_BURST_LEN-1:0]      rd_len_q, rd_len_d;
    logic [READ_BURST_LEN:0]        rd_beat_q, rd_beat_d;
    logic                           rd_done_q, rd_done_d;
    logic [READ_CHANNEL_WIDTH-1:0]  rd_last_data_q, rd_last_data_d;

    // ---------------- read slave ----------------
    logic                           ar_valid;
    logic                           ar_ready;
    logic                           rs_active_q;
    logic [MEM_ADDR_WIDTH-1:0]      rs_ptr_q;
    logic [READ_BURST_LEN-1:0]      rs_left_q;
    logic                           r_valid_q;
    logic                           r_last_q;
    logic [READ_CHANNEL_WIDTH-1:0]  r_data_q;

    // ---------------- write master ----------------
    wr_state_t                      wr_state_q, wr_state_d;
    logic [ADDR_WIDTH-1:0]          wr_addr_q, wr_addr_d;
    logic [WRITE_BURST_LEN-1:0]     wr_len_q, wr_len_d;
    logic [WRITE_BURST_LEN:0]       wr_beat_q, wr_beat_d;
    logic                           wr_done_q, wr_done_d;
    logic                           wr_last;
    logic                           fifo_push;
    logic                           fifo_full;
    logic [WRITE_CHANNEL_WIDTH:0]   fifo_wdata;

    // ---------------- write slave ----------------
    logic                           aw_valid;
    logic                           b_ready;
    logic                           fifo_pop;
    logic                           fifo_empty;
    logic [WRITE_CHANNEL_WIDTH:0]   fifo_rdata;
    logic                           fifo_rlast;
    logic [WRITE_CHANNEL_WIDTH-1:0] fifo_rword;
    logic                           mem_we;
    logic [MEM_ADDR_WIDTH-1:0]      ws_ptr_q;
    logic                           b_valid_q;
    logic [1:0]                     b_resp_q;

    logic [WRITE_CHANNEL_WIDTH-1:0] mem_q [2**MEM_ADDR_WIDTH];

    logic                           unused_bits;

    assign dma_page_fault_done = rd_done_q;
    assign dma_write_back_done = wr_done_q;

    always_comb begin
        rd_state_d     = rd_state_q;
        rd_addr_d      = rd_addr_q;
        rd_len_d       = rd_len_q;
        rd_beat_d      = rd_beat_q;
        rd_done_d      = rd_done_q;
        rd_last_data_d = rd_last_data_q;
        case (rd_state_q)
            RD_IDLE: begin
                rd_done_d = 1'b0;
                if (dma_page_fault_happen) begin
                    rd_addr_d  = dma_page_fault_addr[MEM_ADDR_WIDTH-1:0];
                    rd_len_d   = dma_page_fault_burst_len;
                    rd_beat_d  = '0;
                    rd_state_d = RD_AR;
                end
            end
            RD_AR: begin
                if (ar_ready) begin
                    rd_state_d = RD_R;
                end
            end
            RD_R: begin
                if (r_valid_q) begin
                    rd_beat_d      = rd_beat_q + RD_BEAT_ONE;
                    rd_last_data_d = r_data_q;
                    if (r_last_q) begin
                        rd_state_d = RD_DONE;
                    end
                end
            end
            RD_DONE: begin
                // A request dropped mid-burst lands here with happen low: skip done.
                rd_done_d = dma_page_fault_happen;
                if (!dma_page_fault_happen) begin
                    rd_state_d = RD_IDLE;
                end
            end
            default: rd_state_d = RD_IDLE;
        endcase
    end

    always_ff @(posedge cpu_clk) begin
        if (!cpu_rst_n) begin
            rd_state_q     <= RD_IDLE;
            rd_addr_q      <= '0;
            rd_len_q       <= '0;
            rd_beat_q      <= '0;
            rd_done_q      <= 1'b0;
            rd_last_data_q <= '0;
        end else begin
            rd_state_q     <= rd_state_d;
            rd_addr_q      <= rd_addr_d;
            rd_len_q       <= rd_len_d;
            rd_beat_q      <= rd_beat_d;
            rd_done_q      <= rd_done_d;
            rd_last_data_q <= rd_last_data_d;
        end
    end

    assign ar_valid = (rd_state_q == RD_AR);
    assign ar_ready = !rs_active_q;

    // Synchronous read port: each beat's data appears the cycle after its address.
    always_ff @(posedge cpu_clk) begin
        if (!cpu_rst_n) begin
            rs_active_q <= 1'b0;
            rs_ptr_q    <= '0;
            rs_left_q   <= '0;
            r_valid_q   <= 1'b0;
            r_last_q    <= 1'b0;
        end else begin
            r_valid_q <= rs_active_q;
            r_last_q  <= rs_active_q && (rs_left_q == '0);
            if (rs_active_q) begin
                rs_ptr_q  <= rs_ptr_q + MEM_ONE;
                rs_left_q <= rs_left_q - RD_LEN_ONE;
                if (rs_left_q == '0) begin
                    rs_active_q <= 1'b0;
                end
            end else if (ar_valid) begin
                rs_ptr_q    <= rd_addr_q;
                rs_left_q   <= rd_len_q;
                rs_active_q <= 1'b1;
            end
        end
    end

    always_ff @(posedge cpu_clk) begin
        if (rs_active_q) begin
            r_data_q <= mem_q[rs_ptr_q];
        end
    end

    assign wr_last    = (wr_beat_q == {1'b0, wr_len_q});
    assign fifo_wdata = {wr_last, WRITE_CHANNEL_WIDTH'(wr_addr_q + ADDR_WIDTH'(wr_beat_q))};

    always_comb begin
        wr_state_d = wr_state_q;
        wr_addr_d  = wr_addr_q;
        wr_len_d   = wr_len_q;
        wr_beat_d  = wr_beat_q;
        wr_done_d  = wr_done_q;
        fifo_push  = 1'b0;
        case (wr_state_q)
            WR_IDLE: begin
                wr_done_d = 1'b0;
                if (dma_write_back_happen) begin
                    wr_addr_d  = dma_write_back_addr;
                    wr_len_d   = dma_write_back_burst_len;
                    wr_beat_d  = '0;
                    wr_state_d = WR_AW;
                end
            end
            WR_AW: begin
                wr_state_d = WR_W;
            end
            WR_W: begin
                fifo_push = 1'b1;
                if (!fifo_full) begin
                    wr_beat_d = wr_beat_q + WR_BEAT_ONE;
                    if (wr_last) begin
                        wr_state_d = WR_B;
                    end
                end
            end
            WR_B: begin
                if (b_valid_q && (b_resp_q == RESP_OKAY)) begin
                    wr_state_d = WR_DONE;
                end
            end
            WR_DONE: begin
                wr_done_d = dma_write_back_happen;
                if (!dma_write_back_happen) begin
                    wr_state_d = WR_IDLE;
                end
            end
            default: wr_state_d = WR_IDLE;
        endcase
    end

    always_ff @(posedge cpu_clk) begin
        if (!cpu_rst_n) begin
            wr_state_q <= WR_IDLE;
            wr_addr_q  <= '0;
            wr_len_q   <= '0;
            wr_beat_q  <= '0;
            wr_done_q  <= 1'b0;
        end else begin
            wr_state_q <= wr_state_d;
            wr_addr_q  <= wr_addr_d;
            wr_len_q   <= wr_len_d;
            wr_beat_q  <= wr_beat_d;
            wr_done_q  <= wr_done_d;
        end
    end

    sync_fifo #(
        .WIDTH      (WRITE_CHANNEL_WIDTH + 1),
        .ADDR_WIDTH (ASYNCFIFO_ADDR_WIDTH)
    ) u_fifo (
        .clk_i   (cpu_clk),
        .rst_ni  (cpu_rst_n),
        .push_i  (fifo_push),
        .wdata_i (fifo_wdata),
        .full_o  (fifo_full),
        .pop_i   (fifo_pop),
        .rdata_o (fifo_rdata),
        .empty_o (fifo_empty)
    );

    assign aw_valid   = (wr_state_q == WR_AW);
    assign b_ready    = (wr_state_q == WR_B);
    assign fifo_pop   = !fifo_empty;
    assign fifo_rlast = fifo_rdata[WRITE_CHANNEL_WIDTH];
    assign fifo_rword = fifo_rdata[WRITE_CHANNEL_WIDTH-1:0];
    // Gate on reset so an aborting reset edge does not commit one more word.
    assign mem_we     = cpu_rst_n && fifo_pop;

    always_ff @(posedge cpu_clk) begin
        if (!cpu_rst_n) begin
            ws_ptr_q  <= '0;
            b_valid_q <= 1'b0;
            b_resp_q  <= RESP_OKAY;
        end else begin
            if (aw_valid) begin
                ws_ptr_q <= wr_addr_q[MEM_ADDR_WIDTH-1:0];
            end else if (fifo_pop) begin
                ws_ptr_q <= ws_ptr_q + MEM_ONE;
            end
            if (fifo_pop && fifo_rlast) begin
                b_valid_q <= 1'b1;
                b_resp_q  <= RESP_OKAY;
            end else if (b_ready) begin
                b_valid_q <= 1'b0;
            end
        end
    end

    // Read-before-write: a same-cycle read of this word sees the old value.
    always_ff @(posedge cpu_clk) begin
        if (mem_we) begin
            mem_q[ws_ptr_q] <= fifo_rword;
        end
    end

    assign unused_bits = ^{dma_page_fault_addr[ADDR_WIDTH-1:MEM_ADDR_WIDTH], rd_last_data_q, rd_beat_q};

endmodule

// File: tb/tb_bus_dma_master_memory_slave.sv
// Directed bench for the DMA master / memory slave: handshakes, latency,
// burst contents, address wrap, concurrency and mid-transfer reset.
module tb_bus_dma_master_memory_slave;
    import bus_dma_pkg::*;

    logic        cpu_clk;
    logic        cpu_rst_n;
    logic        dma_page_fault_happen;
    logic        dma_page_fault_done;
    logic [31:0] dma_page_fault_addr;
    logic [7:0]  dma_page_fault_burst_len;
    logic        dma_write_back_happen;
    logic        dma_write_back_done;
    logic [31:0] dma_write_back_addr;
    logic [7:0]  dma_write_back_burst_len;

    int n_checks = 0;
    int n_errors = 0;

    bus_dma_master_memory_slave dut (
        .cpu_clk                  (cpu_clk),
        .cpu_rst_n                (cpu_rst_n),
        .dma_page_fault_happen    (dma_page_fault_happen),
        .dma_page_fault_done      (dma_page_fault_done),
        .dma_page_fault_addr      (dma_page_fault_addr),
        .dma_page_fault_burst_len (dma_page_fault_burst_len),
        .dma_write_back_happen    (dma_write_back_happen),
        .dma_write_back_done      (dma_write_back_done),
        .dma_write_back_addr      (dma_write_back_addr),
        .dma_write_back_burst_len (dma_write_back_burst_len)
    );

    initial cpu_clk = 1'b0;
    always #5 cpu_clk = ~cpu_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic memchk(input string tag, input int base, input int n);
        logic [5:0] idx;
        for (int i = 0; i < n; i++) begin
            idx = 6'(base + i);
            chk($sformatf("%s_mem%0d", tag, idx), dut.mem_q[idx], 32'(base + i));
        end
    endtask

    // Runs a read and/or write request through the full 4-phase handshake.
    // Latency is counted in clock edges after the edge that samples happen.
    task automatic run(input bit do_rd, input int ra, input int rl,
                       input bit do_wr, input int wa, input int wl, input string tag);
        int cyc;
        int rd_lat;
        int wr_lat;
        int beats;
        int last_at;
        rd_lat  = -1;
        wr_lat  = -1;
        beats   = 0;
        last_at = -1;
        @(negedge cpu_clk);
        if (do_rd) begin
            dma_page_fault_addr      = 32'(ra);
            dma_page_fault_burst_len = 8'(rl);
            dma_page_fault_happen    = 1'b1;
        end
        if (do_wr) begin
            dma_write_back_addr      = 32'(wa);
            dma_write_back_burst_len = 8'(wl);
            dma_write_back_happen    = 1'b1;
        end
        cyc = 0;
        while (cyc < 400 && ((do_rd && rd_lat < 0) || (do_wr && wr_lat < 0))) begin
            @(negedge cpu_clk);
            cyc++;
            if (dut.r_valid_q) begin
                beats++;
                if (dut.r_last_q) last_at = beats;
            end
            if (do_rd && rd_lat < 0 && dma_page_fault_done) rd_lat = cyc - 1;
            if (do_wr && wr_lat < 0 && dma_write_back_done) wr_lat = cyc - 1;
        end
        if (do_rd) begin
            chk({tag, "_rd_latency"}, 32'(rd_lat), 32'(rl + 4));
            chk({tag, "_rd_beats"}, 32'(beats), 32'(rl + 1));
            chk({tag, "_rlast_beat"}, 32'(last_at), 32'(rl + 1));
        end
        if (do_wr) chk({tag, "_wr_latency"}, 32'(wr_lat), 32'(wl + 5));
        @(negedge cpu_clk);
        if (do_rd) chk({tag, "_rd_done_hold"}, 32'(dma_page_fault_done), 32'd1);
        if (do_wr) chk({tag, "_wr_done_hold"}, 32'(dma_write_back_done), 32'd1);
        dma_page_fault_happen = 1'b0;
        dma_write_back_happen = 1'b0;
        @(negedge cpu_clk);
        if (do_rd) begin
            chk({tag, "_rd_done_drop"}, 32'(dma_page_fault_done), 32'd0);
            chk({tag, "_rd_idle"}, 32'(dut.rd_state_q), 32'(RD_IDLE));
        end
        if (do_wr) begin
            chk({tag, "_wr_done_drop"}, 32'(dma_write_back_done), 32'd0);
            chk({tag, "_wr_idle"}, 32'(dut.wr_state_q), 32'(WR_IDLE));
        end
    endtask

    initial begin
        int guard;
        cpu_rst_n                = 1'b0;
        dma_page_fault_happen    = 1'b0;
        dma_page_fault_addr      = '0;
        dma_page_fault_burst_len = '0;
        dma_write_back_happen    = 1'b0;
        dma_write_back_addr      = '0;
        dma_write_back_burst_len = '0;
        repeat (3) @(negedge cpu_clk);
        cpu_rst_n = 1'b1;
        @(negedge cpu_clk);
        chk("reset_rd_done", 32'(dma_page_fault_done), 32'd0);
        chk("reset_wr_done", 32'(dma_write_back_done), 32'd0);
        chk("reset_rd_state", 32'(dut.rd_state_q), 32'(RD_IDLE));
        chk("reset_wr_state", 32'(dut.wr_state_q), 32'(WR_IDLE));
        chk("reset_fifo_empty", 32'(dut.u_fifo.empty_o), 32'd1);

        run(1'b0, 0, 0, 1'b1, 8, 19, "wr8");
        memchk("wr8", 8, 20);

        run(1'b1, 15, 2, 1'b0, 0, 0, "rd15");
        chk("rd15_last_data", dut.rd_last_data_q, 32'd17);

        run(1'b1, 8, 0, 1'b0, 0, 0, "rd8");
        chk("rd8_last_data", dut.rd_last_data_q, 32'd8);

        run(1'b0, 0, 0, 1'b1, 40, 7, "wr40");
        memchk("wr40", 40, 8);

        run(1'b1, 25, 19, 1'b1, 2, 9, "conc");
        memchk("conc", 2, 10);
        chk("conc_last_data", dut.rd_last_data_q, 32'd44);

        run(1'b0, 0, 0, 1'b1, 60, 7, "wrap");
        memchk("wrap", 60, 8);

        @(negedge cpu_clk);
        dma_write_back_addr      = 32'd48;
        dma_write_back_burst_len = 8'd15;
        dma_write_back_happen    = 1'b1;
        guard = 0;
        while (dut.wr_beat_q != 9'd5 && guard < 50) begin
            @(negedge cpu_clk);
            guard++;
        end
        chk("rst_reach_beat5", 32'(guard < 50), 32'd1);
        cpu_rst_n             = 1'b0;
        dma_write_back_happen = 1'b0;
        @(negedge cpu_clk);
        cpu_rst_n = 1'b1;
        chk("rst_wr_done", 32'(dma_write_back_done), 32'd0);
        chk("rst_fifo_empty", 32'(dut.u_fifo.empty_o), 32'd1);
        chk("rst_wr_state", 32'(dut.wr_state_q), 32'(WR_IDLE));
        chk("rst_wr_beat", 32'(dut.wr_beat_q), 32'd0);
        chk("rst_mem_kept", dut.mem_q[6'd48], 32'd48);

        run(1'b0, 0, 0, 1'b1, 30, 3, "after_rst");
        memchk("after_rst", 30, 4);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
